sequenciador_estacoes: RTL and testbench

Parametrised master sequencer for the wine bottling line: drives one bottle at a time past `N_EST` process stations (filling, sealing, QC, …), handshaking with each station's slave FSM, then routes the bottle to discard or final output. Counts approved bottles in batches of `LOTE` and counts completed batches. Sits between the debounced START pulse and the station slave FSMs, in place of the fixed three-station master, and feeds the approved and batch counts to the display decoders.

---
 rtl/sequenciador_estacoes.sv | 209 ++++++++++++++++++++
 tb/tb_sequenciador_estacoes.sv | 391 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sequenciador_estacoes.sv
`default_nettype none
// ============================================================================
// sequenciador_estacoes : bottling-line master sequencer (N_EST stations,
//   discard/exit routing, approved-bottle and batch counters)   Rev 1.0
// ============================================================================
module sequenciador_estacoes #(
  parameter int N_EST     = 3,
  parameter int LOTE      = 12,
  parameter int CNT_W     = 7,
  parameter int LOTES_MAX = 99,
  parameter int TIMEOUT   = 1000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             parar,
  input  logic             bloqueio,
  input  logic [N_EST-1:0] enable_est,
  input  logic [N_EST-1:0] sensor_pos,
  input  logic             sensor_descarte,
  input  logic             sensor_final,
  input  logic [N_EST-1:0] est_concluida,
  input  logic [N_EST-1:0] est_reprova,
  output logic             motor_ativo,
  output logic [N_EST-1:0] cmd_est,
  output logic             descarte_ativo,
  output logic             lote_completo,
  output logic [CNT_W-1:0] contador_aprovadas,
  output logic [CNT_W-1:0] contador_lotes,
  output logic             erro_timeout
);

  localparam int KW = $clog2(N_EST + 1);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [KW-1:0]    K_LAST    = KW'(N_EST);
  localparam logic [KW-1:0]    K_ONE     = KW'(1);
  localparam logic [TW-1:0]    TMR_ONE   = TW'(1);
  localparam logic [TW-1:0]    TMR_END   = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_END   = CNT_W'(LOTE - 1);
  localparam logic [CNT_W-1:0] LOTES_SAT = CNT_W'(LOTES_MAX);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_AVANCA    = 4'd1,
    S_MOVER     = 4'd2,
    S_EXEC      = 4'd3,
    S_MOV_DESC  = 4'd4,
    S_DESCARTE  = 4'd5,
    S_MOV_FINAL = 4'd6,
    S_CONTA     = 4'd7,
    S_ERRO      = 4'd8
  } state_t;

  state_t           state, state_nx;
  logic [KW-1:0]    k, k_nx;
  logic             rej, rej_nx;
  logic [TW-1:0]    tmr, tmr_nx;
  logic [CNT_W-1:0] cnt_ap, cnt_ap_nx;
  logic [CNT_W-1:0] cnt_lt, cnt_lt_nx;
  logic             lote_pulse, lote_pulse_nx;

  logic en_k, pos_k, done_k, rej_k;

  // Per-station inputs selected by the current index; k==N_EST selects nothing.
  always_comb begin
    en_k   = 1'b0;
    pos_k  = 1'b0;
    done_k = 1'b0;
    rej_k  = 1'b0;
    for (int i = 0; i < N_EST; i++) begin
      if (k == KW'(i)) begin
        en_k   = enable_est[i];
        pos_k  = sensor_pos[i];
        done_k = est_concluida[i];
        rej_k  = est_reprova[i];
      end
    end
  end

  always_comb begin
    state_nx      = state;
    k_nx          = k;
    rej_nx        = rej;
    tmr_nx        = tmr;
    cnt_ap_nx     = cnt_ap;
    cnt_lt_nx     = cnt_lt;
    lote_pulse_nx = 1'b0;

    if (parar && (state != S_IDLE)) begin
      state_nx = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state_nx  = S_AVANCA;
            k_nx      = '0;
            rej_nx    = 1'b0;
            cnt_ap_nx = '0;
            cnt_lt_nx = '0;
          end
        end
        S_AVANCA: begin
          if (k == K_LAST) begin
            state_nx = rej ? S_MOV_DESC : S_MOV_FINAL;
          end else if (en_k) begin
            state_nx = S_MOVER;
          end else begin
            k_nx = k + K_ONE;
          end
        end
        S_MOVER: begin
          if (!bloqueio && pos_k) begin
            state_nx = S_EXEC;
            tmr_nx   = '0;
          end
        end
        S_EXEC: begin
          if (done_k) begin
            rej_nx   = rej | rej_k;
            k_nx     = k + K_ONE;
            state_nx = S_AVANCA;
          end else if ((TIMEOUT != 0) && (tmr == TMR_END)) begin
            state_nx = S_ERRO;
          end else begin
            tmr_nx = tmr + TMR_ONE;
          end
        end
        S_MOV_DESC: begin
          if (!bloqueio && sensor_descarte) begin
            state_nx = S_DESCARTE;
          end
        end
        S_DESCARTE: begin
          if (!sensor_descarte) begin
            state_nx = S_AVANCA;
            k_nx     = '0;
            rej_nx   = 1'b0;
          end
        end
        S_MOV_FINAL: begin
          if (!bloqueio && sensor_final) begin
            state_nx = S_CONTA;
          end
        end
        S_CONTA: begin
          state_nx = S_AVANCA;
          k_nx     = '0;
          rej_nx   = 1'b0;
          // Closing a batch wraps the bottle count; batch count saturates.
          if (cnt_ap == CNT_END) begin
            cnt_ap_nx     = '0;
            lote_pulse_nx = 1'b1;
            if (cnt_lt < LOTES_SAT) begin
              cnt_lt_nx = cnt_lt + CNT_ONE;
            end
          end else begin
            cnt_ap_nx = cnt_ap + CNT_ONE;
          end
        end
        S_ERRO: begin
          if (start) begin
            state_nx = S_IDLE;
          end
        end
        default: begin
          state_nx = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      k          <= '0;
      rej        <= 1'b0;
      tmr        <= '0;
      cnt_ap     <= '0;
      cnt_lt     <= '0;
      lote_pulse <= 1'b0;
    end else begin
      state      <= state_nx;
      k          <= k_nx;
      rej        <= rej_nx;
      tmr        <= tmr_nx;
      cnt_ap     <= cnt_ap_nx;
      cnt_lt     <= cnt_lt_nx;
      lote_pulse <= lote_pulse_nx;
    end
  end

  // The conveyor interlock gates the motor immediately, independent of state.
  assign motor_ativo = ((state == S_MOVER) || (state == S_MOV_DESC) ||
                        (state == S_MOV_FINAL)) && !bloqueio;

  for (genvar gi = 0; gi < N_EST; gi++) begin : g_cmd
    assign cmd_est[gi] = (state == S_EXEC) && (k == KW'(gi));
  end

  assign descarte_ativo     = (state == S_DESCARTE);
  assign erro_timeout       = (state == S_ERRO);
  assign lote_completo      = lote_pulse;
  assign contador_aprovadas = cnt_ap;
  assign contador_lotes     = cnt_lt;

endmodule
`default_nettype wire

// File: tb/tb_sequenciador_estacoes.sv
`default_nettype none
// tb_sequenciador_estacoes : bottle-level plant model with scoreboard queues
// for station commands, discard events and counter updates.
module tb_sequenciador_estacoes;

  localparam int N     = 3;
  localparam int LOTE  = 12;
  localparam int CNT_W = 7;
  localparam int LMAX  = 99;
  localparam int TMO   = 20;

  typedef struct {
    int cnt;
    int lotes;
    bit pulse;
  } cnt_rec_t;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
  logic             parar = 1'b0;
  logic             bloqueio = 1'b0;
  logic [N-1:0]     enable_est = '0;
  logic [N-1:0]     sensor_pos = '0;
  logic             sensor_descarte = 1'b0;
  logic             sensor_final = 1'b0;
  logic [N-1:0]     est_concluida = '0;
  logic [N-1:0]     est_reprova = '0;
  logic             motor_ativo;
  logic [N-1:0]     cmd_est;
  logic             descarte_ativo;
  logic             lote_completo;
  logic [CNT_W-1:0] contador_aprovadas;
  logic [CNT_W-1:0] contador_lotes;
  logic             erro_timeout;

  always #5 clk = ~clk;

  sequenciador_estacoes #(
    .N_EST(N), .LOTE(LOTE), .CNT_W(CNT_W), .LOTES_MAX(LMAX), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .parar(parar), .bloqueio(bloqueio),
    .enable_est(enable_est), .sensor_pos(sensor_pos),
    .sensor_descarte(sensor_descarte), .sensor_final(sensor_final),
    .est_concluida(est_concluida), .est_reprova(est_reprova),
    .motor_ativo(motor_ativo), .cmd_est(cmd_est), .descarte_ativo(descarte_ativo),
    .lote_completo(lote_completo), .contador_aprovadas(contador_aprovadas),
    .contador_lotes(contador_lotes), .erro_timeout(erro_timeout)
  );

  int       n_vec = 0;
  int       n_err = 0;
  bit       abort = 0;
  int       total = 0;   // approved bottles since the last counter clear
  logic [N-1:0] q_cmd[$];
  cnt_rec_t     q_cnt[$];
  cnt_rec_t     q_disc[$];

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic cnt_rec_t model_now(input bit pulse);
    cnt_rec_t r;
    r.cnt   = total % LOTE;
    r.lotes = (total / LOTE > LMAX) ? LMAX : total / LOTE;
    r.pulse = pulse;
    return r;
  endfunction

  task automatic model_clear();
    if (total != 0) q_cnt.push_back('{0, 0, 1'b0});
    total = 0;
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic [N-1:0]     prev_cmd = '0;
  logic             prev_desc = 1'b0;
  logic             prev_lote = 1'b0;
  logic [CNT_W-1:0] prev_cnt = '0;
  logic [CNT_W-1:0] prev_lotes = '0;

  always @(negedge clk) begin : monitor
    logic [N-1:0] e_cmd;
    cnt_rec_t     r;
    if (prev_cmd == '0 && cmd_est != '0) begin
      if (q_cmd.size() == 0) chk("cmd_unexpected", int'(cmd_est), 0);
      else begin
        e_cmd = q_cmd.pop_front();
        chk("cmd_est", int'(cmd_est), int'(e_cmd));
      end
    end
    if (!prev_desc && descarte_ativo) begin
      if (q_disc.size() == 0) chk("discard_unexpected", 1, 0);
      else begin
        r = q_disc.pop_front();
        chk("discard_cnt_kept", int'(contador_aprovadas), r.cnt);
        chk("discard_lotes_kept", int'(contador_lotes), r.lotes);
      end
    end
    if (contador_aprovadas != prev_cnt || contador_lotes != prev_lotes) begin
      if (q_cnt.size() == 0) chk("counter_unexpected", int'(contador_aprovadas), int'(prev_cnt));
      else begin
        r = q_cnt.pop_front();
        chk("contador_aprovadas", int'(contador_aprovadas), r.cnt);
        chk("contador_lotes", int'(contador_lotes), r.lotes);
        chk("lote_completo", int'(lote_completo), int'(r.pulse));
      end
    end else if (lote_completo) begin
      chk("lote_stray", 1, 0);
    end
    if (lote_completo && prev_lote) chk("lote_width", 2, 1);
    prev_cmd   = cmd_est;
    prev_desc  = descarte_ativo;
    prev_lote  = lote_completo;
    prev_cnt   = contador_aprovadas;
    prev_lotes = contador_lotes;
  end

  // ---------------- plant helpers ----------------
  function automatic bit sig_is(input int w);
    case (w)
      0:       return motor_ativo;
      1:       return cmd_est != '0;
      2:       return descarte_ativo;
      default: return erro_timeout;
    endcase
  endfunction

  task automatic wait_for(input int which, input string name);
    int c = 0;
    if (abort) return;
    while (!sig_is(which)) begin
      @(negedge clk);
      c++;
      if (c > 200) begin
        n_vec++;
        n_err++;
        $display("FAIL wait_%s: no response after %0d cycles, expected one", name, c);
        abort = 1;
        return;
      end
    end
  endtask

  task automatic motor_delay();
    int d = $urandom_range(0, 2);
    repeat (d) begin
      @(negedge clk);
      chk("motor_hold", int'(motor_ativo), 1);
    end
  endtask

  // One bottle through the line: en = enabled stations, rj = reject flags.
  task automatic bottle(input logic [N-1:0] en, input logic [N-1:0] rj, input bit blk);
    bit           rejected = 0;
    bit           first = 1;
    logic [N-1:0] one, bitm;
    int           d, c, nxt;
    if (abort) return;
    enable_est = en;
    one = 1;
    for (int i = 0; i < N; i++) begin
      if (en[i]) begin
        q_cmd.push_back(one << i);
        rejected |= rj[i];
      end
    end
    if (rejected) q_disc.push_back(model_now(1'b0));
    else begin
      total++;
      q_cnt.push_back(model_now(total % LOTE == 0));
    end

    for (int i = 0; i < N; i++) begin
      if (!en[i]) continue;
      if (first) wait_for(0, "motor_station");
      first = 0;
      if (abort) return;
      bitm = one << i;
      if (blk) begin
        bloqueio = 1'b1;
        sensor_pos = bitm;
        repeat (3) begin
          @(negedge clk);
          chk("blk_motor", int'(motor_ativo), 0);
          chk("blk_cmd", int'(cmd_est), 0);
        end
        bloqueio = 1'b0;
        blk = 0;
      end else begin
        motor_delay();
        sensor_pos = bitm;
      end
      wait_for(1, "cmd");
      if (abort) return;
      sensor_pos = '0;
      d = $urandom_range(0, 3);
      repeat (d) begin
        est_concluida = N'($urandom_range(0, 7)) & ~bitm;
        est_reprova   = N'($urandom_range(0, 7));
        @(negedge clk);
      end
      est_concluida = bitm | (N'($urandom_range(0, 7)) & ~bitm);
      est_reprova   = N'($urandom_range(0, 7)) & ~bitm;
      if (rj[i]) est_reprova = est_reprova | bitm;
      nxt = N;
      for (int j = N - 1; j > i; j--) if (en[j]) nxt = j;
      @(negedge clk);
      est_concluida = '0;
      est_reprova   = '0;
      c = 1;
      while (!motor_ativo && c < 50) begin
        @(negedge clk);
        c++;
      end
      chk("avanca_gap", c, nxt - i + 1);
    end

    if (first) wait_for(0, "motor_out");
    if (abort) return;
    motor_delay();
    if (rejected) begin
      sensor_descarte = 1'b1;
      wait_for(2, "descarte");
      if (abort) return;
      d = $urandom_range(1, 3);
      repeat (d) begin
        @(negedge clk);
        chk("descarte_hold", int'(descarte_ativo), 1);
      end
      sensor_descarte = 1'b0;
      @(negedge clk);
      chk("descarte_release", int'(descarte_ativo), 0);
    end else begin
      sensor_final = 1'b1;
      @(negedge clk);
      chk("conta_motor", int'(motor_ativo), 0);
      sensor_final = 1'b0;
    end
  endtask

  // Bring the current bottle into EXEC at station 0 and return there.
  task automatic reach_exec0();
    if (abort) return;
    enable_est = 3'b001;
    q_cmd.push_back(3'b001);
    wait_for(0, "motor_exec0");
    sensor_pos = 3'b001;
    wait_for(1, "cmd_exec0");
    sensor_pos = '0;
  endtask

  task automatic restart();
    model_clear();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_motor"}, int'(motor_ativo), 0);
    chk({tag, "_cmd"}, int'(cmd_est), 0);
    chk({tag, "_descarte"}, int'(descarte_ativo), 0);
    chk({tag, "_lote"}, int'(lote_completo), 0);
    chk({tag, "_erro"}, int'(erro_timeout), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [N-1:0] en, rj;
    cnt_rec_t     r;
    int           c;

    repeat (3) @(negedge clk);
    check_all_zero("reset");
    chk("reset_cnt", int'(contador_aprovadas), 0);
    chk("reset_lotes", int'(contador_lotes), 0);
    reset = 1'b1;
    @(negedge clk);
    chk("idle_motor", int'(motor_ativo), 0);

    enable_est = 3'b111;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_t1_motor", int'(motor_ativo), 0);
    @(negedge clk);
    chk("start_t2_motor", int'(motor_ativo), 1);

    bottle(3'b111, 3'b000, 0);
    bottle(3'b101, 3'b000, 0);
    bottle(3'b111, 3'b100, 0);
    bottle(3'b111, 3'b010, 1);
    bottle(3'b000, 3'b111, 0);

    for (int b = 0; b < 40; b++) begin
      en = N'($urandom_range(0, 7));
      for (int i = 0; i < N; i++) rj[i] = ($urandom_range(0, 3) == 0);
      bottle(en, rj, $urandom_range(0, 3) == 0);
    end

    // Station never reports done: timeout to ERRO, then start back to IDLE.
    reach_exec0();
    if (!abort) begin
      c = 0;
      while (!erro_timeout && c < 100) begin
        @(negedge clk);
        c++;
      end
      chk("timeout_cycles", c, TMO);
      chk("erro_motor", int'(motor_ativo), 0);
      chk("erro_cmd", int'(cmd_est), 0);
      chk("erro_descarte", int'(descarte_ativo), 0);
      r = model_now(1'b0);
      chk("erro_cnt_kept", int'(contador_aprovadas), r.cnt);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("erro_clear", int'(erro_timeout), 0);
      repeat (3) @(negedge clk);
      chk("idle_after_erro_motor", int'(motor_ativo), 0);
      restart();
    end

    for (int b = 0; b < 10; b++) begin
      en = N'($urandom_range(0, 7));
      for (int i = 0; i < N; i++) rj[i] = ($urandom_range(0, 3) == 0);
      bottle(en, rj, 0);
    end

    // Abort from EXEC: back to IDLE next cycle, counters kept.
    reach_exec0();
    if (!abort) begin
      parar = 1'b1;
      @(negedge clk);
      parar = 1'b0;
      chk("parar_cmd", int'(cmd_est), 0);
      chk("parar_motor", int'(motor_ativo), 0);
      r = model_now(1'b0);
      chk("parar_cnt_kept", int'(contador_aprovadas), r.cnt);
      chk("parar_lotes_kept", int'(contador_lotes), r.lotes);
      repeat (3) @(negedge clk);
      chk("parar_idle_motor", int'(motor_ativo), 0);
      restart();
    end

    // Batch closing and batch-counter saturation, using fast all-bypass bottles.
    for (int b = 0; b < LOTE * (LMAX + 1); b++) bottle(3'b000, 3'b000, 0);
    if (!abort) begin
      @(negedge clk);
      chk("lotes_saturated", int'(contador_lotes), LMAX);
      chk("cnt_after_saturation", int'(contador_aprovadas), 0);
    end

    // Asynchronous reset in the middle of EXEC.
    reach_exec0();
    if (!abort) begin
      model_clear();
      #2 reset = 1'b0;
      #1;
      check_all_zero("async_reset");
      chk("async_reset_cnt", int'(contador_aprovadas), 0);
      chk("async_reset_lotes", int'(contador_lotes), 0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      restart();
      bottle(3'b111, 3'b000, 0);
    end

    repeat (4) @(negedge clk);
    chk("q_cmd_left", q_cmd.size(), 0);
    chk("q_cnt_left", q_cnt.size(), 0);
    chk("q_disc_left", q_disc.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: time limit reached before completion, expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
